// File: rtl/lv_scan_reg_bist.sv
// Scan-register parity BIST: reads every register of the LV scan bank once per pass,
// checks even parity and reports the pass result as an ack burst to the BIST controller.
module lv_scan_reg_bist #(
    parameter int LV_SCAN_REG_NUM = 16,
    parameter int SCAN_REG_DW     = 8
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_bist_scan_reg_req,
    output logic                                  o_scan_reg_bist_ack,
    output logic                                  o_scan_reg_bist_err,
    output logic                                  o_scan_rd_en,
    output logic [$clog2(LV_SCAN_REG_NUM)-1:0]    o_scan_rd_addr,
    input  logic [SCAN_REG_DW-1:0]                i_scan_rd_data,
    input  logic                                  i_scan_rd_par,
    output logic [$clog2(LV_SCAN_REG_NUM)-1:0]    o_scan_err_addr,
    output logic                                  o_scan_busy
);

    localparam int SCAN_ADDR_W = $clog2(LV_SCAN_REG_NUM);
    localparam logic [SCAN_ADDR_W-1:0] LAST_ADDR = SCAN_ADDR_W'(LV_SCAN_REG_NUM - 1);
    localparam logic [SCAN_ADDR_W:0]   RPT_LAST  = (SCAN_ADDR_W + 1)'(LV_SCAN_REG_NUM - 1);
    localparam logic [SCAN_ADDR_W:0]   RPT_SAT   = (SCAN_ADDR_W + 1)'(LV_SCAN_REG_NUM);

    typedef enum logic [2:0] {IDLE, RD, CHK, RPT, GAP} state_t;

    state_t                 state_q, state_d;
    logic [SCAN_ADDR_W-1:0] addr_q, addr_d;
    logic [SCAN_ADDR_W:0]   rpt_cnt_q, rpt_cnt_d;
    logic                   err_q, err_d;
    logic [SCAN_ADDR_W-1:0] err_addr_q, err_addr_d;
    logic                   ack_q, ack_d;
    logic                   err_out_q, err_out_d;
    logic                   rd_en_q, rd_en_d;
    logic [SCAN_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic                   busy_q, busy_d;
    logic                   par_fail;

    assign par_fail = (^i_scan_rd_data) != i_scan_rd_par;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            rpt_cnt_q  <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            ack_q      <= 1'b0;
            err_out_q  <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rpt_cnt_q  <= rpt_cnt_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            ack_q      <= ack_d;
            err_out_q  <= err_out_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rpt_cnt_d  = rpt_cnt_q;
        err_d      = err_q;
        err_addr_d = err_addr_q;
        unique case (state_q)
            IDLE: begin
                if (i_bist_scan_reg_req) begin
                    state_d    = RD;
                    addr_d     = '0;
                    err_d      = 1'b0;
                    err_addr_d = '0;
                end
            end
            RD: begin
                if (!i_bist_scan_reg_req) begin
                    state_d    = IDLE;
                    addr_d     = '0;
                    err_d      = 1'b0;
                    err_addr_d = '0;
                end else begin
                    state_d = CHK;
                end
            end
            CHK: begin
                // An abort discards the partial result rather than reporting it.
                if (!i_bist_scan_reg_req) begin
                    state_d    = IDLE;
                    addr_d     = '0;
                    err_d      = 1'b0;
                    err_addr_d = '0;
                end else begin
                    err_d = err_q | par_fail;
                    if (par_fail && !err_q) begin
                        err_addr_d = addr_q;
                    end
                    if (addr_q == LAST_ADDR) begin
                        state_d   = RPT;
                        rpt_cnt_d = '0;
                    end else begin
                        state_d = RD;
                        addr_d  = addr_q + SCAN_ADDR_W'(1);
                    end
                end
            end
            RPT: begin
                if (rpt_cnt_q == RPT_LAST) begin
                    state_d = GAP;
                end
                if (rpt_cnt_q != RPT_SAT) begin
                    rpt_cnt_d = rpt_cnt_q + (SCAN_ADDR_W + 1)'(1);
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        ack_d     = (state_d == RPT);
        err_out_d = (state_d == RPT) && err_d;
        rd_en_d   = (state_d == RD);
        rd_addr_d = (state_d == RD) ? addr_d : rd_addr_q;
        busy_d    = (state_d != IDLE);
    end

    assign o_scan_reg_bist_ack = ack_q;
    assign o_scan_reg_bist_err = err_out_q;
    assign o_scan_rd_en        = rd_en_q;
    assign o_scan_rd_addr      = rd_addr_q;
    assign o_scan_err_addr     = err_addr_q;
    assign o_scan_busy         = busy_q;

endmodule
